instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit words in the internal instruction store; must be a power of 2, at most 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, byte address of store word 0.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, with release synchronous to clk.
REQ-005 Port prog_we  input  1  store write enable; accepted only in IDLE.
REQ-006 Port prog_addr  input  4  word index written when prog_we=1.
REQ-007 Port prog_data  input  32  word written at prog_addr.
REQ-008 Port prog_len  input  5  number of words to issue; sampled at start.
REQ-009 Port start  input  1  begin issuing from word 0; accepted only in IDLE.
REQ-010 Port instr_ready  input  1  downstream R-type datapath can accept an instruction this cycle.
REQ-011 Port instruction  output  32  issued instruction word, fed directly to the R-type top's instruction input.
REQ-012 Port instr_valid  output  1  instruction holds a valid word.
REQ-013 Port pc  output  32  byte address of the word on instruction.
REQ-014 Port busy  output  1  state is not IDLE.
REQ-015 Port done  output  1  single-cycle pulse when the last word is accepted.

Function
REQ-016 States: IDLE, RUN, FIN; busy=1 in RUN and FIN.
REQ-017 IDLE: when prog_we=1, write prog_data to store[prog_addr]; when prog_addr>=DEPTH, ignore the write.
REQ-018 IDLE with start=1: latch len = min(prog_len, DEPTH), clear the word counter, go to RUN; prog_we in the same cycle takes effect first.
REQ-019 When len=0 at start: go to FIN without ever asserting instr_valid.
REQ-020 Store read is synchronous: instr_valid rises in the second cycle after start is sampled, carrying store[0] and pc=RESET_PC.
REQ-021 Handshake: a word is transferred on a cycle where instr_valid=1 and instr_ready=1.
REQ-022 While instr_valid=1 and instr_ready=0: instruction and pc stay stable and are not dropped.
REQ-023 On a transfer of word k<len-1: the next cycle shows word k+1 with pc+4, for 1 word/cycle throughput when instr_ready is held at 1.
REQ-024 On a transfer of word len-1: instr_valid drops the next cycle and the state goes to FIN.
REQ-025 FIN lasts one cycle with done=1, then returns to IDLE.
REQ-026 In RUN or FIN, start and prog_we are ignored, and the store contents do not change.
REQ-027 pc = RESET_PC + 4*k, computed modulo 2^32.
REQ-028 When instr_valid=0, instruction reads 32'h0000_0000.
REQ-029 The store contents persist across runs and are undefined after power-up until written.

Reset
REQ-030 rst=0 forces: state=IDLE, instr_valid=0, instruction=0, pc=RESET_PC, busy=0, done=0, word counter=0, len=0; the store contents are not required to clear.
REQ-031 Reset mid-RUN abandons the sequence: no done pulse, and no further instr_valid until a new start.
REQ-032 After reset release, the first start behaves exactly as in REQ-018 to REQ-020.

Verification
REQ-033 Program store[0]=32'h004384B3 (add x9,x7,x4) and store[1]=32'h40D289B3 (sub x19,x5,x13), prog_len=2, start, ready held 1 -> valid 2 cycles after start; words 004384B3 then 40D289B3 on consecutive cycles with pc 0 then 4; done pulses 1 cycle after the 2nd transfer.
REQ-034 Same program with instr_ready=0 for 3 cycles while word 0 is valid -> instruction=004384B3 and pc=0 held all 3 cycles; no word skipped or duplicated after ready returns.
REQ-035 prog_len=0 and start -> instr_valid never rises; done pulses exactly once; busy is high for 2 cycles.
REQ-036 prog_len=20 with 16 words programmed -> exactly 16 transfers; last pc=60; done asserted once.
REQ-037 Assert rst=0 asynchronously after the 2nd of 4 transfers -> outputs reach reset values without a clk edge; no done; a new start reissues from word 0 with pc=0.
REQ-038 prog_we and start pulsed while busy -> store is unchanged (verified by the next run's words), and the current sequence is unaffected.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch
//   Small programmable instruction store that streams its words, in order,
//   to a downstream R-type datapath over a valid/ready handshake.
//
//   Ports
//     clk, rst          clock; asynchronous active-low reset
//     prog_we/addr/data store write port (honoured only while idle)
//     prog_len          number of words to issue, sampled with start
//     start             begin issuing from word 0 (honoured only while idle)
//     instr_ready       downstream accepts the presented word this cycle
//     instruction       presented word (zero when instr_valid is low)
//     instr_valid       instruction/pc hold a valid word
//     pc                byte address of the presented word
//     busy              sequence in progress (RUN or FIN)
//     done              one-cycle pulse after the last word is accepted
module instr_fetch #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [31:0] prog_data,
    input  logic [4:0]  prog_len,
    input  logic        start,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        busy,
    output logic        done
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_W = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state;
    logic [31:0] store [DEPTH];
    logic [4:0]  len;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nxt;
    logic        take;

    assign cnt_nxt = cnt + 5'd1;
    assign take    = instr_valid & instr_ready;
    assign busy    = (state != IDLE);

    // Store is plain RAM: no reset, written only while idle. A write in the
    // same cycle as start lands before the first read one cycle later.
    always_ff @(posedge clk) begin
        if (state == IDLE && prog_we && 32'(prog_addr) < DEPTH)
            store[prog_addr[AW-1:0]] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instruction <= 32'h0;
            pc          <= RESET_PC;
            done        <= 1'b0;
            cnt         <= 5'd0;
            len         <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
                        cnt   <= 5'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!instr_valid) begin
                        // First RUN cycle: synchronous read of word 0, or an
                        // empty program heading straight to FIN.
                        if (cnt < len) begin
                            instruction <= store[cnt[AW-1:0]];
                            instr_valid <= 1'b1;
                            pc          <= RESET_PC;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else if (take) begin
                        if (cnt_nxt == len) begin
                            instr_valid <= 1'b0;
                            instruction <= 32'h0;
                            pc          <= RESET_PC;
                            cnt         <= cnt_nxt;
                            state       <= FIN;
                            done        <= 1'b1;
                        end else begin
                            // Read ahead of the transfer so a held ready gives
                            // one word per cycle.
                            cnt         <= cnt_nxt;
                            instruction <= store[cnt_nxt[AW-1:0]];
                            pc          <= pc + 32'd4;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'h0;
    logic [31:0] prog_data = 32'h0;
    logic [4:0]  prog_len = 5'd0;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int ndone;
    logic [31:0] mstore [16];

    instr_fetch #(.DEPTH(16), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .instr_ready(instr_ready), .instruction(instruction),
        .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic prog(input logic [3:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mstore[a] = d;
    endtask

    // Reference: the run issues min(plen,16) words mstore[0..] at pc 4*k,
    // first valid in cycle 2 after start, done the cycle after the last
    // transfer (cycle 2 for an empty run), busy through the done cycle.
    // mode: 0 ready held, 1 random ready, 2 ready low cycles 2..4.
    task automatic run(input int plen, input int mode, input bit disturb, input int abort);
        int  elen, idx, c, dcyc;
        bit  vexp, xfer;
        elen  = (plen > 16) ? 16 : plen;
        idx   = 0;
        dcyc  = (elen == 0) ? 2 : 1000;
        ndone = 0;
        prog_len = 5'(plen);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (c <= dcyc + 1) begin
            if (c > 200) begin
                chk("timeout", 32'(c), 32'd0);
                break;
            end
            instr_ready = (mode == 0) ? 1'b1 :
                          (mode == 1) ? 1'($urandom_range(0, 1)) :
                          !(c >= 2 && c < 5);
            if (disturb && c <= dcyc) begin
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = 4'($urandom);
                prog_data = $urandom;
                start     = 1'($urandom_range(0, 1));
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            @(negedge clk);
            vexp = (c >= 2) && (idx < elen);
            chk("valid", 32'(instr_valid), 32'(vexp));
            chk("instr", instruction, vexp ? mstore[idx] : 32'h0);
            if (vexp) chk("pc", pc, 32'(4 * idx));
            chk("done", 32'(done), 32'(c == dcyc));
            chk("busy", 32'(busy), 32'(c <= dcyc));
            if (done) ndone++;
            xfer = vexp && instr_ready;
            @(posedge clk); #1;
            c++;
            if (xfer) begin
                idx++;
                if (idx == elen) dcyc = c;
            end
            if (abort > 0 && xfer && idx == abort) begin
                prog_we = 1'b0; start = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("arst_valid", 32'(instr_valid), 32'd0);
                chk("arst_instr", instruction, 32'h0);
                chk("arst_pc", pc, 32'h0);
                chk("arst_busy", 32'(busy), 32'd0);
                chk("arst_done", 32'(done), 32'd0);
                break;
            end
        end
        prog_we = 1'b0;
        start   = 1'b0;
        if (abort == 0) begin
            chk("xfers", 32'(idx), 32'(elen));
            chk("done_count", 32'(ndone), 32'd1);
        end else begin
            chk("abort_done_count", 32'(ndone), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) mstore[i] = 32'h0;
        for (int i = 0; i < 16; i++) prog(4'(i), 32'h0);

        // add / sub pair, ready held, then ready stalled on word 0
        prog(4'd0, 32'h004384B3);
        prog(4'd1, 32'h40D289B3);
        run(2, 0, 1'b0, 0);
        run(2, 2, 1'b0, 0);

        // empty program
        run(0, 0, 1'b0, 0);

        // full store, over-long length clamps to 16
        for (int i = 0; i < 16; i++) prog(4'(i), $urandom);
        run(20, 0, 1'b0, 0);

        // writes/starts while busy are ignored; next run shows store intact
        run(4, 1, 1'b1, 0);
        run(16, 0, 1'b0, 0);

        // async reset after 2nd of 4 transfers
        run(4, 0, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(instr_valid), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        run(4, 0, 1'b0, 0);

        // random programs, lengths and ready patterns
        for (int r = 0; r < 12; r++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) prog(4'($urandom), $urandom);
            run($urandom_range(0, 20), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
